array_seq_ctrl: RTL and testbench

//  Sequencer for one systolic-array tile pass inside core. On a start pulse it performs, in order:

---
 rtl/array_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_array_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_seq_ctrl.sv
// Systolic-array tile pass sequencer: weight load, activation stream + execute,
// then output drain. Drives the core inst bus and both SRAM ports.
module array_seq_ctrl #(
  parameter int                row      = 8,
  parameter int                col      = 8,
  parameter int                addr_w   = 11,
  parameter logic [addr_w-1:0] WGT_BASE = 11'h400,
  parameter logic [addr_w-1:0] ACT_BASE = 11'h000,
  parameter logic [addr_w-1:0] OUT_BASE = 11'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] cfg_len,
  input  logic              cfg_relu,
  input  logic              ofifo_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        inst,
  output logic              cen_act_wgt,
  output logic              wen_act_wgt,
  output logic [addr_w-1:0] addr_act_wgt,
  output logic              cen_out,
  output logic              wen_out,
  output logic [addr_w-1:0] addr_out
);

  typedef enum logic [2:0] {
    IDLE, WLOAD, WPUSH, ALOAD, EXEC, DRAIN, DONE
  } state_e;

  localparam int CW = addr_w + 1;
  localparam logic [CW-1:0] ROW_C     = CW'(row);
  localparam logic [CW-1:0] COL_C     = CW'(col);
  localparam logic [CW-1:0] PUSH_LAST = CW'(row + col - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [addr_w-1:0] len_q, len_d;
  logic              relu_q, relu_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        inst_q, inst_d;
  logic              cen_aw_q, cen_aw_d;
  logic [addr_w-1:0] addr_aw_q, addr_aw_d;
  logic              cen_out_q, cen_out_d;
  logic              wen_out_q, wen_out_d;
  logic [addr_w-1:0] addr_out_q, addr_out_d;

  logic [CW-1:0] len_x, len_xd;
  assign len_x  = {1'b0, len_q};
  assign len_xd = {1'b0, len_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      relu_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inst_q     <= '0;
      cen_aw_q   <= 1'b1;
      addr_aw_q  <= '0;
      cen_out_q  <= 1'b1;
      wen_out_q  <= 1'b1;
      addr_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      relu_q     <= relu_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inst_q     <= inst_d;
      cen_aw_q   <= cen_aw_d;
      addr_aw_q  <= addr_aw_d;
      cen_out_q  <= cen_out_d;
      wen_out_q  <= wen_out_d;
      addr_out_q <= addr_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    relu_d  = relu_q;
    unique case (state_q)
      IDLE: if (start) begin
        len_d   = cfg_len;
        relu_d  = cfg_relu;
        cnt_d   = '0;
        state_d = (cfg_len == '0) ? DONE : WLOAD;
      end
      WLOAD: if (cnt_q == ROW_C) begin
        state_d = WPUSH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      WPUSH: if (cnt_q == PUSH_LAST) begin
        state_d = ALOAD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      ALOAD: if (cnt_q == len_x) begin
        state_d = EXEC;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      EXEC: if (cnt_q == len_x + COL_C - 1'b1) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      // result index advances only on a completed write cycle
      DRAIN: if (!cen_out_q) begin
        if (cnt_q == len_x - 1'b1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    inst_d     = '0;
    inst_d[1]  = ~cen_aw_q;
    inst_d[5]  = relu_d & (state_d != IDLE);
    cen_aw_d   = 1'b1;
    addr_aw_d  = '0;
    cen_out_d  = 1'b1;
    wen_out_d  = 1'b1;
    addr_out_d = '0;
    unique case (state_d)
      WLOAD: if (cnt_d < ROW_C) begin
        cen_aw_d  = 1'b0;
        addr_aw_d = WGT_BASE + cnt_d[addr_w-1:0];
      end
      WPUSH: begin
        inst_d[2] = 1'b1;
        inst_d[0] = (cnt_d < ROW_C);
      end
      ALOAD: if (cnt_d < len_xd) begin
        cen_aw_d  = 1'b0;
        addr_aw_d = ACT_BASE + cnt_d[addr_w-1:0];
      end
      EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[0] = (cnt_d < len_xd);
      end
      DRAIN: if (state_q == DRAIN && inst_q[4]) begin
        cen_out_d  = 1'b0;
        wen_out_d  = 1'b0;
        addr_out_d = OUT_BASE + cnt_d[addr_w-1:0];
      end else inst_d[4] = ofifo_valid;
      default: ;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign inst         = inst_q;
  assign cen_act_wgt  = cen_aw_q;
  assign wen_act_wgt  = 1'b1;
  assign addr_act_wgt = addr_aw_q;
  assign cen_out      = cen_out_q;
  assign wen_out      = wen_out_q;
  assign addr_out     = addr_out_q;

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Bench for array_seq_ctrl: address scoreboards plus per-pass
// activity counters and cycle-by-cycle invariants.
module tb_array_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam logic [AW-1:0] WGT = 11'h400;
  localparam logic [AW-1:0] ACT = 11'h000;
  localparam logic [AW-1:0] OUT = 11'h000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_len = '0;
  logic          cfg_relu = 1'b0;
  logic          ofifo_valid = 1'b1;
  logic          busy, done;
  logic [7:0]    inst;
  logic          cen_act_wgt, wen_act_wgt;
  logic [AW-1:0] addr_act_wgt;
  logic          cen_out, wen_out;
  logic [AW-1:0] addr_out;

  array_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .ofifo_valid(ofifo_valid),
    .busy(busy), .done(done), .inst(inst),
    .cen_act_wgt(cen_act_wgt),
    .wen_act_wgt(wen_act_wgt),
    .addr_act_wgt(addr_act_wgt),
    .cen_out(cen_out), .wen_out(wen_out),
    .addr_out(addr_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] aw_q[$];
  logic [AW-1:0] out_q[$];
  logic [AW-1:0] exp_a;
  logic          relu_exp = 1'b0;
  logic          v1 = 1'b0, v2 = 1'b0;

  int n_busy, n_done, n_exec, n_kl, n_rd;
  int n_wr, n_aw, n_l0wr, n_l0rd, n_relu;

  task automatic clear_counts();
    n_busy = 0; n_done = 0; n_exec = 0;
    n_kl = 0; n_rd = 0; n_wr = 0; n_aw = 0;
    n_l0wr = 0; n_l0rd = 0; n_relu = 0;
  endtask

  always @(negedge clk) begin
    if (busy)      n_busy++;
    if (done)      n_done++;
    if (inst[3])   n_exec++;
    if (inst[2])   n_kl++;
    if (inst[4])   n_rd++;
    if (inst[1])   n_l0wr++;
    if (inst[0])   n_l0rd++;
    if (inst[5])   n_relu++;
    if (!cen_out && !wen_out) n_wr++;
    if (!cen_act_wgt) begin
      n_aw++;
      checks++;
      if (aw_q.size() == 0) begin
        errors++;
        $display("FAIL aw_extra got=%h want=none",
                 addr_act_wgt);
      end else begin
        exp_a = aw_q.pop_front();
        if (addr_act_wgt !== exp_a) begin
          errors++;
          $display("FAIL aw_addr got=%h want=%h",
                   addr_act_wgt, exp_a);
        end
      end
    end
    if (!cen_out) begin
      checks++;
      if (out_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra got=%h want=none",
                 addr_out);
      end else begin
        exp_a = out_q.pop_front();
        if (addr_out !== exp_a || wen_out !== 1'b0) begin
          errors++;
          $display("FAIL out_addr got=%h/%b want=%h/0",
                   addr_out, wen_out, exp_a);
        end
      end
    end
    checks++;
    if ((inst[2] && inst[3]) ||
        (!cen_act_wgt && !cen_out) ||
        wen_act_wgt !== 1'b1 ||
        inst[7:6] !== 2'b00) begin
      errors++;
      $display("FAIL invariant got inst=%b cen=%b%b want=legal",
               inst, cen_act_wgt, cen_out);
    end
    checks++;
    if (inst[5] !== (busy & relu_exp)) begin
      errors++;
      $display("FAIL relu_bit got=%b want=%b",
               inst[5], busy & relu_exp);
    end
    checks++;
    if ((inst[4] && !v1) || (!cen_out && !v2)) begin
      errors++;
      $display("FAIL drain_hs got rd=%b cen_out=%b want=idle",
               inst[4], cen_out);
    end
    v2 = v1;
    v1 = ofifo_valid;
  end

  task automatic pulse_start(input int len, input bit relu);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_len = AW'(len);
    cfg_relu = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_pass(input int len, input bit relu);
    if (len > 0) begin
      for (int k = 0; k < ROW; k++) aw_q.push_back(WGT + AW'(k));
      for (int n = 0; n < len; n++) aw_q.push_back(ACT + AW'(n));
      for (int m = 0; m < len; m++) out_q.push_back(OUT + AW'(m));
    end
    relu_exp = relu;
    pulse_start(len, relu);
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int pass_cycles(input int len);
    return (len == 0) ? 1 :
      (ROW + 1) + (ROW + COL) + (len + 1) + (len + COL) + 2 * len + 1;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (inst !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        cen_act_wgt !== 1'b1 || cen_out !== 1'b1 ||
        wen_out !== 1'b1 || addr_act_wgt !== '0 ||
        addr_out !== '0) begin
      errors++;
      $display("FAIL reset_vals got i=%h b=%b d=%b c=%b%b want=idle",
               inst, busy, done, cen_act_wgt, cen_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    clear_counts();
    ofifo_valid = 1'b1;
    start_pass(4, 1'b0);
    wait_done(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t2_done got=timeout want=done");
    end
    checks++;
    if (n_busy !== pass_cycles(4)) begin
      errors++;
      $display("FAIL t2_busy got=%0d want=%0d",
               n_busy, pass_cycles(4));
    end
    checks++;
    if (n_exec !== 12 || n_kl !== 16) begin
      errors++;
      $display("FAIL t2_exec_kl got=%0d/%0d want=12/16",
               n_exec, n_kl);
    end
    checks++;
    if (n_l0wr !== 12 || n_l0rd !== 12) begin
      errors++;
      $display("FAIL t2_l0 got=%0d/%0d want=12/12",
               n_l0wr, n_l0rd);
    end
    checks++;
    if (n_done !== 1 || n_wr !== 4 || n_rd !== 4 || n_aw !== 12) begin
      errors++;
      $display("FAIL t2_counts got d=%0d w=%0d r=%0d a=%0d want=1/4/4/12",
               n_done, n_wr, n_rd, n_aw);
    end
    checks++;
    if (aw_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL t2_sb_left got=%0d/%0d want=0/0",
               aw_q.size(), out_q.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    clear_counts();
    ofifo_valid = 1'b1;
    start_pass(4, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_exec > 1) break;
    end
    checks++;
    if (n_exec <= 1) begin
      errors++;
      $display("FAIL t1_reach_exec got=%0d want=2", n_exec);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    aw_q.delete();
    out_q.delete();
    @(negedge clk);
    checks++;
    if (inst !== 8'h00 || cen_act_wgt !== 1'b1 ||
        cen_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_abort got i=%h c=%b%b b=%b want=00/11/0",
               inst, cen_act_wgt, cen_out, busy);
    end
    clear_counts();
    start_pass(4, 1'b0);
    wait_done(500, ok);
    checks++;
    if (!ok || n_busy !== pass_cycles(4) || n_wr !== 4) begin
      errors++;
      $display("FAIL t1_clean got ok=%b b=%0d w=%0d want=1/%0d/4",
               ok, n_busy, n_wr, pass_cycles(4));
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_counts();
    ofifo_valid = 1'b1;
    start_pass(3, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_wr >= 1) break;
    end
    @(posedge clk); #1;
    ofifo_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ofifo_valid = 1'b1;
    wait_done(500, ok);
    checks++;
    if (!ok || n_done !== 1) begin
      errors++;
      $display("FAIL t3_done got ok=%b d=%0d want=1/1", ok, n_done);
    end
    checks++;
    if (n_wr !== 3 || n_rd !== 3) begin
      errors++;
      $display("FAIL t3_writes got w=%0d r=%0d want=3/3",
               n_wr, n_rd);
    end
    checks++;
    if (n_busy <= pass_cycles(3) || out_q.size() != 0) begin
      errors++;
      $display("FAIL t3_stall got b=%0d q=%0d want>%0d/0",
               n_busy, out_q.size(), pass_cycles(3));
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_counts();
    ofifo_valid = 1'b1;
    start_pass(4, 1'b0);
    repeat (3) @(posedge clk);
    pulse_start(7, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_exec > 0) break;
    end
    pulse_start(9, 1'b1);
    wait_done(500, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || n_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_one_done got ok=%b d=%0d b=%b want=1/1/0",
               ok, n_done, busy);
    end
    checks++;
    if (n_busy !== pass_cycles(4) || n_aw !== 12) begin
      errors++;
      $display("FAIL t4_busy got b=%0d a=%0d want=%0d/12",
               n_busy, n_aw, pass_cycles(4));
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    clear_counts();
    start_pass(0, 1'b0);
    wait_done(20, ok);
    checks++;
    if (!ok || n_busy !== 1 || n_done !== 1) begin
      errors++;
      $display("FAIL t5_len0 got ok=%b b=%0d d=%0d want=1/1/1",
               ok, n_busy, n_done);
    end
    checks++;
    if (n_aw !== 0 || n_wr !== 0 || n_exec !== 0 || n_kl !== 0) begin
      errors++;
      $display("FAIL t5_no_sram got a=%0d w=%0d e=%0d k=%0d want=0",
               n_aw, n_wr, n_exec, n_kl);
    end
  endtask

  task automatic test_relu();
    bit ok;
    clear_counts();
    ofifo_valid = 1'b1;
    start_pass(2, 1'b1);
    wait_done(500, ok);
    checks++;
    if (!ok || n_relu !== pass_cycles(2) || n_busy !== pass_cycles(2)) begin
      errors++;
      $display("FAIL t6_relu got ok=%b r=%0d b=%0d want=1/%0d/%0d",
               ok, n_relu, n_busy, pass_cycles(2), pass_cycles(2));
    end
    checks++;
    if (inst[5] !== 1'b0 || n_wr !== 2) begin
      errors++;
      $display("FAIL t6_idle got r=%b w=%0d want=0/2", inst[5], n_wr);
    end
    relu_exp = 1'b0;
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_basic();
    test_reset_mid_exec();
    test_stall();
    test_start_ignored();
    test_len_zero();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
